// File: rtl/sap_control_sequencer_if.sv
// Control bundle between the SAP sequencer and the rest of the datapath:
// sequencing inputs, the five bus-driver enables and every load/control strobe.
interface sap_control_sequencer_if #(
   parameter int STEP_BITS = 3
);
   logic                 run;
   logic                 step;
   logic [3:0]           opcode;
   logic                 carryFlag;
   logic                 zeroFlag;
   logic                 CO, IO, AO, SO, RO;
   logic                 MI, RI, II, AI, BI, OI;
   logic                 CE, J, SU, FI;
   logic                 halted;
   logic [STEP_BITS-1:0] tState;

   modport master (
      input  run, step, opcode, carryFlag, zeroFlag,
      output CO, IO, AO, SO, RO, MI, RI, II, AI, BI, OI, CE, J, SU, FI,
      output halted, tState
   );

   modport slave (
      output run, step, opcode, carryFlag, zeroFlag,
      input  CO, IO, AO, SO, RO, MI, RI, II, AI, BI, OI, CE, J, SU, FI,
      input  halted, tState
   );
endinterface

// File: rtl/sap_control_sequencer.sv
// Microcoded SAP control unit: decodes (microstep, opcode) into the control word
// and advances the microstep only in active cycles (run, step edge, not halted).
module sap_control_sequencer #(
   parameter int STEP_BITS = 3
) (
   input  logic                          clock,
   input  logic                          resetN,
   sap_control_sequencer_if.master       ctl
);

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_t;

   typedef struct packed {
      logic CO, IO, AO, SO, RO;
      logic MI, RI, II, AI, BI, OI;
      logic CE, J, SU, FI;
   } ctrl_t;

   logic [STEP_BITS-1:0] r_tState;
   logic                 r_halted;
   logic                 r_stepPrev;

   logic                 w_active;
   logic                 w_last;
   logic                 w_halt;
   opcode_t              w_op;
   ctrl_t                w_word;
   ctrl_t                w_out;

   assign w_op     = opcode_t'(ctl.opcode);
   assign w_active = resetN & ~r_halted & (ctl.run | (ctl.step & ~r_stepPrev));

   // Microcode ROM; any step past an instruction's last one decodes to nothing and wraps.
   always_comb begin
      w_word = '0;
      w_last = 1'b0;
      w_halt = 1'b0;
      case (r_tState)
         STEP_BITS'(0): begin
            w_word.CO = 1'b1;
            w_word.MI = 1'b1;
         end
         STEP_BITS'(1): begin
            w_word.RO = 1'b1;
            w_word.II = 1'b1;
            w_word.CE = 1'b1;
         end
         STEP_BITS'(2): begin
            case (w_op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  w_word.IO = 1'b1;
                  w_word.MI = 1'b1;
               end
               OP_LDI: begin
                  w_word.IO = 1'b1;
                  w_word.AI = 1'b1;
                  w_last    = 1'b1;
               end
               OP_JMP: begin
                  w_word.IO = 1'b1;
                  w_word.J  = 1'b1;
                  w_last    = 1'b1;
               end
               OP_JC: begin
                  w_word.IO = ctl.carryFlag;
                  w_word.J  = ctl.carryFlag;
                  w_last    = 1'b1;
               end
               OP_JZ: begin
                  w_word.IO = ctl.zeroFlag;
                  w_word.J  = ctl.zeroFlag;
                  w_last    = 1'b1;
               end
               OP_OUT: begin
                  w_word.AO = 1'b1;
                  w_word.OI = 1'b1;
                  w_last    = 1'b1;
               end
               OP_HLT: begin
                  w_halt = 1'b1;
                  w_last = 1'b1;
               end
               default: w_last = 1'b1;
            endcase
         end
         STEP_BITS'(3): begin
            case (w_op)
               OP_LDA: begin
                  w_word.RO = 1'b1;
                  w_word.AI = 1'b1;
                  w_last    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  w_word.RO = 1'b1;
                  w_word.BI = 1'b1;
               end
               OP_STA: begin
                  w_word.AO = 1'b1;
                  w_word.RI = 1'b1;
                  w_last    = 1'b1;
               end
               default: w_last = 1'b1;
            endcase
         end
         STEP_BITS'(4): begin
            w_last = 1'b1;
            if (w_op == OP_ADD || w_op == OP_SUB) begin
               w_word.SO = 1'b1;
               w_word.AI = 1'b1;
               w_word.FI = 1'b1;
               w_word.SU = (w_op == OP_SUB);
            end
         end
         default: w_last = 1'b1;
      endcase
   end

   assign w_out = w_active ? w_word : '0;

   always_ff @(posedge clock) begin
      if (!resetN) begin
         r_tState   <= '0;
         r_halted   <= 1'b0;
         r_stepPrev <= 1'b0;
      end else begin
         r_stepPrev <= ctl.step;
         if (w_active) begin
            if (w_halt) begin
               r_halted <= 1'b1;
               r_tState <= '0;
            end else if (w_last) begin
               r_tState <= '0;
            end else begin
               r_tState <= r_tState + STEP_BITS'(1);
            end
         end
      end
   end

   assign ctl.CO     = w_out.CO;
   assign ctl.IO     = w_out.IO;
   assign ctl.AO     = w_out.AO;
   assign ctl.SO     = w_out.SO;
   assign ctl.RO     = w_out.RO;
   assign ctl.MI     = w_out.MI;
   assign ctl.RI     = w_out.RI;
   assign ctl.II     = w_out.II;
   assign ctl.AI     = w_out.AI;
   assign ctl.BI     = w_out.BI;
   assign ctl.OI     = w_out.OI;
   assign ctl.CE     = w_out.CE;
   assign ctl.J      = w_out.J;
   assign ctl.SU     = w_out.SU;
   assign ctl.FI     = w_out.FI;
   assign ctl.halted = r_halted;
   assign ctl.tState = r_tState;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: each driven cycle queues its
// hand-computed control word, microstep and halt state for the monitor.
module tb_sap_control_sequencer;

   localparam logic [14:0] B_CO = 15'h4000, B_IO = 15'h2000, B_AO = 15'h1000;
   localparam logic [14:0] B_SO = 15'h0800, B_RO = 15'h0400, B_MI = 15'h0200;
   localparam logic [14:0] B_RI = 15'h0100, B_II = 15'h0080, B_AI = 15'h0040;
   localparam logic [14:0] B_BI = 15'h0020, B_OI = 15'h0010, B_CE = 15'h0008;
   localparam logic [14:0] B_J  = 15'h0004, B_SU = 15'h0002, B_FI = 15'h0001;
   localparam logic [14:0] NONE = 15'h0000;

   typedef struct {
      logic [14:0] ctrl;
      logic [2:0]  t;
      logic        h;
   } exp_t;

   logic clock;
   logic resetN;
   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];

   sap_control_sequencer_if #(.STEP_BITS(3)) ctl ();

   sap_control_sequencer #(.STEP_BITS(3)) dut (
      .clock  (clock),
      .resetN (resetN),
      .ctl    (ctl)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle's inputs just after the edge and queue what that cycle must show.
   task automatic applyStimulus(input logic rn, input logic r, input logic s,
                                input logic [3:0] op, input logic cf, input logic zf,
                                input logic [14:0] expCtrl, input logic [2:0] expT,
                                input logic expH);
      exp_t e;
      @(posedge clock);
      #1;
      resetN        = rn;
      ctl.run       = r;
      ctl.step      = s;
      ctl.opcode    = op;
      ctl.carryFlag = cf;
      ctl.zeroFlag  = zf;
      e.ctrl = expCtrl;
      e.t    = expT;
      e.h    = expH;
      expQ.push_back(e);
   endtask

   task automatic fetchCycles(input logic [3:0] op);
      applyStimulus(1, 1, 0, op, 0, 0, B_CO | B_MI, 3'd0, 0);
      applyStimulus(1, 1, 0, op, 0, 0, B_RO | B_II | B_CE, 3'd1, 0);
   endtask

   task automatic checkOutput(input exp_t e, input logic [14:0] gotCtrl,
                              input logic [2:0] gotT, input logic gotH);
      checks++;
      if (gotCtrl !== e.ctrl) begin
         errors++;
         $display("[TB] FAIL ctrl @%0t got %h want %h", $time, gotCtrl, e.ctrl);
      end
      checks++;
      if (gotT !== e.t) begin
         errors++;
         $display("[TB] FAIL tState @%0t got %0d want %0d", $time, gotT, e.t);
      end
      checks++;
      if (gotH !== e.h) begin
         errors++;
         $display("[TB] FAIL halted @%0t got %b want %b", $time, gotH, e.h);
      end
   endtask

   // Monitor: mid-cycle, check the bus-enable invariant and retire one queued expectation.
   always @(negedge clock) begin
      logic [14:0] got;
      logic [4:0]  busEn;
      exp_t        e;
      got   = {ctl.CO, ctl.IO, ctl.AO, ctl.SO, ctl.RO, ctl.MI, ctl.RI, ctl.II,
               ctl.AI, ctl.BI, ctl.OI, ctl.CE, ctl.J, ctl.SU, ctl.FI};
      busEn = {ctl.CO, ctl.IO, ctl.AO, ctl.SO, ctl.RO};
      checks++;
      if ($countones(busEn) > 1) begin
         errors++;
         $display("[TB] FAIL busInvariant @%0t got enables %b want at most one", $time, busEn);
      end
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
         checkOutput(e, got, ctl.tState, ctl.halted);
      end
   end

   initial begin
      resetN        = 1'b0;
      ctl.run       = 1'b0;
      ctl.step      = 1'b0;
      ctl.opcode    = 4'h0;
      ctl.carryFlag = 1'b0;
      ctl.zeroFlag  = 1'b0;

      applyStimulus(0, 1, 0, 4'h1, 0, 0, NONE, 3'd0, 0);

      // LDA
      fetchCycles(4'h1);
      applyStimulus(1, 1, 0, 4'h1, 0, 0, B_IO | B_MI, 3'd2, 0);
      applyStimulus(1, 1, 0, 4'h1, 0, 0, B_RO | B_AI, 3'd3, 0);
      // SUB
      fetchCycles(4'h3);
      applyStimulus(1, 1, 0, 4'h3, 0, 0, B_IO | B_MI, 3'd2, 0);
      applyStimulus(1, 1, 0, 4'h3, 0, 0, B_RO | B_BI, 3'd3, 0);
      applyStimulus(1, 1, 0, 4'h3, 0, 0, B_SO | B_SU | B_AI | B_FI, 3'd4, 0);
      // JC not taken, then taken
      fetchCycles(4'h7);
      applyStimulus(1, 1, 0, 4'h7, 0, 1, NONE, 3'd2, 0);
      fetchCycles(4'h7);
      applyStimulus(1, 1, 0, 4'h7, 1, 0, B_IO | B_J, 3'd2, 0);
      // JZ taken, then not taken with carry set
      fetchCycles(4'h8);
      applyStimulus(1, 1, 0, 4'h8, 0, 1, B_IO | B_J, 3'd2, 0);
      fetchCycles(4'h8);
      applyStimulus(1, 1, 0, 4'h8, 1, 0, NONE, 3'd2, 0);
      // STA, OUT, LDI, JMP, undefined
      fetchCycles(4'h4);
      applyStimulus(1, 1, 0, 4'h4, 0, 0, B_IO | B_MI, 3'd2, 0);
      applyStimulus(1, 1, 0, 4'h4, 0, 0, B_AO | B_RI, 3'd3, 0);
      fetchCycles(4'hE);
      applyStimulus(1, 1, 0, 4'hE, 0, 0, B_AO | B_OI, 3'd2, 0);
      fetchCycles(4'h5);
      applyStimulus(1, 1, 0, 4'h5, 0, 0, B_IO | B_AI, 3'd2, 0);
      fetchCycles(4'h6);
      applyStimulus(1, 1, 0, 4'h6, 0, 0, B_IO | B_J, 3'd2, 0);
      fetchCycles(4'hB);
      applyStimulus(1, 1, 0, 4'hB, 0, 0, NONE, 3'd2, 0);

      // Single-step: held high gives one step, low gap holds, next rise gives one more
      applyStimulus(1, 0, 1, 4'h1, 0, 0, B_CO | B_MI, 3'd0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 4'h1, 0, 0, NONE, 3'd1, 0);
      for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 4'h1, 0, 0, NONE, 3'd1, 0);
      applyStimulus(1, 0, 1, 4'h1, 0, 0, B_RO | B_II | B_CE, 3'd1, 0);
      applyStimulus(1, 0, 0, 4'h1, 0, 0, NONE, 3'd2, 0);
      applyStimulus(1, 1, 0, 4'h1, 0, 0, B_IO | B_MI, 3'd2, 0);
      applyStimulus(1, 1, 0, 4'h1, 0, 0, B_RO | B_AI, 3'd3, 0);

      // ADD aborted by reset during T3, then HLT
      fetchCycles(4'h2);
      applyStimulus(1, 1, 0, 4'h2, 0, 0, B_IO | B_MI, 3'd2, 0);
      applyStimulus(0, 1, 0, 4'h2, 0, 0, NONE, 3'd3, 0);
      fetchCycles(4'hF);
      applyStimulus(1, 1, 0, 4'hF, 0, 0, NONE, 3'd2, 0);
      for (int i = 0; i < 10; i++)
         applyStimulus(1, 1, logic'(i % 2), 4'hF, 0, 0, NONE, 3'd0, 1);
      applyStimulus(0, 1, 0, 4'h1, 0, 0, NONE, 3'd0, 1);
      applyStimulus(1, 1, 0, 4'h1, 0, 0, B_CO | B_MI, 3'd0, 0);
      applyStimulus(1, 1, 0, 4'h1, 0, 0, B_RO | B_II | B_CE, 3'd1, 0);

      for (int k = 0; k < 10 && expQ.size() != 0; k++) @(negedge clock);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain got %0d pending want 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Microcoded control unit that sequences the shared 8-bit CPU bus and register loads, instruction by instruction.
- Decodes the 4-bit opcode (upper nibble of the instruction register) against a registered microstep counter.
- Drives the five bus-driver enables (CO, IO, AO, SO, RO) consumed by the bus controller, plus all load/increment/control strobes.
- Supports free-run, single-step and halt.

Parameters:
- STEP_BITS, 3, width of the microstep counter; must be at least 3 (steps T0..T4).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetN  in  1  synchronous active-low reset.
- run  in  1  1 = execute one microstep every cycle.
- step  in  1  single-step request; its rising edge executes exactly one microstep while run=0.
- opcode  in  4  instruction register [7:4].
- carryFlag  in  1  registered carry flag from the flags register.
- zeroFlag  in  1  registered zero flag from the flags register.
- CO, IO, AO, SO, RO  out  1 each  bus-driver enables: PC, instruction-register operand, A register, ALU, RAM.
- MI, RI, II, AI, BI, OI  out  1 each  load strobes: MAR, RAM write, instruction register, A, B, output register.
- CE  out  1  PC increment.
- J  out  1  PC load from bus.
- SU  out  1  ALU subtract select.
- FI  out  1  flags register load.
- halted  out  1  sequencer halted.
- tState  out  STEP_BITS  current microstep, for display.

Behaviour:
- **State.** Registered items:
  - microstep counter `tState` (0..4);
  - `haltedReg`;
  - `stepPrev`, the previous value of `step`, used for edge detection.
- **Reset.** When resetN=0 at a clock edge: tState←0, halted←0, stepPrev←0. While resetN is low, all control outputs are forced to 0 combinationally.
- **Active cycle.** Defined as `active = resetN & ~halted & (run | (step & ~stepPrev))`.
  - In an active cycle, the control word for (tState, opcode) is asserted combinationally.
  - At the next edge, tState advances, or wraps to 0 if the current step is the instruction's last.
  - In an inactive cycle, every control output is 0 and tState holds. Pausing therefore never repeats or drops a load strobe.
  - stepPrev←step every cycle. A held step yields exactly one microstep; run=1 overrides step.
- **Fetch (all opcodes).**
  - T0: CO, MI.
  - T1: RO, II, CE.
  - The opcode is sampled as valid from T2 onward.
- **Execute table.** Opcodes in hex. Each entry lists the strobes per step and the length in steps.
  - 0 NOP: T2 none; length 3.
  - 1 LDA: T2 IO,MI; T3 RO,AI; length 4.
  - 2 ADD: T2 IO,MI; T3 RO,BI; T4 SO,AI,FI; length 5.
  - 3 SUB: T2 IO,MI; T3 RO,BI; T4 SO,SU,AI,FI; length 5.
  - 4 STA: T2 IO,MI; T3 AO,RI; length 4.
  - 5 LDI: T2 IO,AI; length 3.
  - 6 JMP: T2 IO,J; length 3.
  - 7 JC: T2 IO,J only if carryFlag=1, else none; length 3.
  - 8 JZ: T2 IO,J only if zeroFlag=1, else none; length 3.
  - E OUT: T2 AO,OI; length 3.
  - F HLT: T2 none; halted←1 at that edge; tState←0.
  - 9–D undefined: treated as NOP.
- **Flags sampling.** JC/JZ sample the flag combinationally during T2. A flag change in the same cycle is honoured.
- **Halt.**
  - Once halted=1, all control outputs are 0 and tState holds 0.
  - run and step are ignored.
  - Only reset clears halt.
- **Bus invariant.** At most one of CO, IO, AO, SO, RO is 1 in any cycle. The verifier asserts this every cycle.
- **Early termination.** The step after the last listed step is never issued. Instruction lengths are exactly as tabled.
- **Reset mid-instruction.** An instruction in progress is abandoned. The first active cycle after reset is T0 of a fresh fetch.
- **Implementation.** tState is compared only within 0..4. Values 5..2^STEP_BITS−1 are unreachable; if ever present, they decode to an all-zero control word and wrap to 0.

Test Plan:
1. Reset, run=1, opcode=1 (LDA) → T0:{CO,MI}, T1:{RO,II,CE}, T2:{IO,MI}, T3:{RO,AI}; tState sequence 0,1,2,3,0; exactly one bus enable per cycle.
2. run=1, opcode=3 (SUB) → T4 asserts SO,SU,AI,FI; tState returns to 0 after 5 cycles; next instruction's T0 asserts CO,MI.
3. opcode=7 with carryFlag=0, then repeated with carryFlag=1 → T2 shows no strobes, then IO,J; both instructions take 3 cycles.
4. run=0, step held high for 4 cycles, then low for 2, then high again → exactly two microsteps executed (tState 0→1→2); outputs 0 during all non-step cycles.
5. opcode=F (HLT), run=1 → halted=1 after T2 edge; 10 further cycles with run=1 and step toggling give all outputs 0 and tState=0; resetN=0 for one cycle → halted=0, T0 strobes resume.
6. resetN driven low during T3 of ADD → outputs 0 while reset is low; next cycle after release is T0 with CO,MI; no BI/AI/FI from the aborted instruction.
